// File: rtl/keccak_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keccak_pkg
//   Shared constants and types for the Keccak sponge front end.
//   - Rate constants for the Kyber hash instances (bits).
//   - Domain-separation bytes for SHAKE and SHA3.
//   - Absorber FSM state encoding.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package keccak_pkg;

  // Rate in bits for each sponge instance
  localparam int RATE_SHAKE128 = 1344;
  localparam int RATE_SHAKE256 = 1088;
  localparam int RATE_SHA3_512 = 576;

  // Domain-separation bytes (suffix bits plus the first pad bit)
  localparam logic [7:0] DS_SHAKE = 8'h1F;
  localparam logic [7:0] DS_SHA3  = 8'h06;

  // Final pad bit lands in the MSB of the last rate byte
  localparam logic [7:0] PAD_LAST = 8'h80;

  // Absorber FSM
  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_EMIT   = 2'd1,
    ST_PADBLK = 2'd2
  } state_e;

endpackage : keccak_pkg
`default_nettype wire

// File: rtl/keccak_pad_word_mask.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keccak_pad_word_mask
//   Combinational byte masker for the last message word.
//   Ports:
//     in_data_i   : raw message word
//     in_bytes_i  : number of valid bytes (values above W/8 act as W/8)
//     data_o      : word with bytes at index >= valid count forced to zero
//     ds_pos_o    : one-hot byte lane receiving the domain byte; all zero
//                   when the word is full (domain byte falls outside it)
//     full_o      : word carries W/8 valid bytes
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module keccak_pad_word_mask #(
  parameter int W  = 64,
  parameter int BW = $clog2(W/8) + 1
) (
  input  logic [W-1:0]   in_data_i,
  input  logic [BW-1:0]  in_bytes_i,
  output logic [W-1:0]   data_o,
  output logic [W/8-1:0] ds_pos_o,
  output logic           full_o
);

  localparam int NB = W / 8;

  int unsigned w_nvalid;

  always_comb begin
    // Clamp oversize counts to a full word
    w_nvalid = (int'(in_bytes_i) > NB) ? NB : int'(in_bytes_i);
    full_o   = (w_nvalid == NB);
    data_o   = '0;
    ds_pos_o = '0;
    for (int i = 0; i < NB; i++) begin
      data_o[8*i +: 8] = (i < w_nvalid) ? in_data_i[8*i +: 8] : 8'h00;
      ds_pos_o[i]      = (i == w_nvalid);
    end
  end

endmodule : keccak_pad_word_mask
`default_nettype wire

// File: rtl/keccak_pad_absorb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keccak_pad_absorb
//   Streaming pad10*1 absorber: packs W-bit message words into R-bit rate
//   blocks, inserts the domain byte DS and the final 0x80 pad bit, and hands
//   complete blocks to the permutation over a valid/ready handshake.
//   Ports:
//     clk, rst                        : clock, async active-high reset
//     in_valid/in_ready               : input word handshake
//     in_data, in_last, in_bytes      : message word, end flag, byte count
//     out_valid/out_ready             : output block handshake
//     out_block, out_last             : rate block, final-block flag
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module keccak_pad_absorb
  import keccak_pkg::*;
#(
  parameter int         R  = RATE_SHAKE128,
  parameter int         W  = 64,
  parameter logic [7:0] DS = DS_SHAKE,
  localparam int        BW = $clog2(W/8) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  input  logic [BW-1:0] in_bytes,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [R-1:0]  out_block,
  output logic          out_last
);

  localparam int NW  = R / W;
  localparam int NB  = W / 8;
  localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [WCW-1:0] WCNT_MAX = WCW'(NW - 1);

  state_e         state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           pend_q, pend_d;   // padding spills into an extra block
  logic           last_q, last_d;
  logic [R-1:0]   block_q, block_d;

  logic [W-1:0]   w_masked;
  logic [NB-1:0]  w_ds_pos;
  logic           w_full;
  logic [W-1:0]   w_ds_word;

  keccak_pad_word_mask #(
    .W  (W),
    .BW (BW)
  ) u_mask (
    .in_data_i  (in_data),
    .in_bytes_i (in_bytes),
    .data_o     (w_masked),
    .ds_pos_o   (w_ds_pos),
    .full_o     (w_full)
  );

  // Domain byte placed in the lane selected by the masker
  for (genvar gi = 0; gi < NB; gi++) begin : g_ds_lane
    assign w_ds_word[8*gi +: 8] = w_ds_pos[gi] ? DS : 8'h00;
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pend_d  = pend_q;
    last_d  = last_q;
    block_d = block_q;

    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          if (!in_last) begin
            block_d[W*wcnt_q +: W] = in_data;
            if (wcnt_q == WCNT_MAX) begin
              state_d = ST_EMIT;
              last_d  = 1'b0;
              wcnt_d  = '0;
            end else begin
              wcnt_d = wcnt_q + WCW'(1);
            end
          end else begin
            state_d = ST_EMIT;
            wcnt_d  = '0;
            block_d[W*wcnt_q +: W] = w_masked ^ w_ds_word;
            if (w_full && (wcnt_q == WCNT_MAX)) begin
              // No room left for the domain byte: defer to a padding block
              pend_d = 1'b1;
              last_d = 1'b0;
            end else begin
              if (w_full) begin
                // Full word below the last slot: domain byte opens the next
                // slot, which is still zero.
                for (int k = 1; k < NW; k++) begin
                  if (k == int'(wcnt_q) + 1) begin
                    block_d[W*k +: 8] = DS;
                  end
                end
              end
              // XOR so a domain byte in the last position merges with 0x80
              block_d[R-1 -: 8] = block_d[R-1 -: 8] ^ PAD_LAST;
              last_d = 1'b1;
            end
          end
        end
      end

      ST_EMIT: begin
        if (out_ready) begin
          if (pend_q) begin
            state_d = ST_PADBLK;
          end else begin
            state_d = ST_FILL;
            block_d = '0;
            last_d  = 1'b0;
          end
        end
      end

      ST_PADBLK: begin
        block_d           = '0;
        block_d[7:0]      = DS;
        block_d[R-1 -: 8] = PAD_LAST;
        pend_d            = 1'b0;
        last_d            = 1'b1;
        state_d           = ST_EMIT;
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      wcnt_q  <= '0;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      block_q <= block_d;
    end
  end

  assign in_ready  = (state_q == ST_FILL);
  assign out_valid = (state_q == ST_EMIT);
  assign out_block = block_q;
  assign out_last  = last_q;

endmodule : keccak_pad_absorb
`default_nettype wire

// File: tb/tb_keccak_pad_absorb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_keccak_pad_absorb
//   Self-checking bench: a SHAKE128 instance and a SHA3-512 instance share the
//   input stimulus (gated by sel). A pad10*1 reference model pushes expected
//   blocks into a scoreboard queue; a monitor pops and compares them on each
//   output handshake.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_keccak_pad_absorb;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_last;
  logic [3:0]  in_bytes;
  logic        out_ready;
  logic        sel;

  logic          a_in_ready, a_out_valid, a_out_last;
  logic [1343:0] a_out_block;
  logic          b_in_ready, b_out_valid, b_out_last;
  logic [575:0]  b_out_block;

  logic          cur_in_ready, cur_out_valid, cur_out_last;
  logic [1343:0] cur_out_block;

  typedef struct {
    logic [1343:0] blk;
    logic          last;
  } exp_t;

  exp_t       sb[$];
  bit [7:0]   msg[$];
  int         total;
  int         bad;
  int         stall_n;
  int         stall_cnt;

  keccak_pad_absorb #(.R(1344), .W(64), .DS(8'h1F)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid && !sel),
    .in_ready  (a_in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .out_valid (a_out_valid),
    .out_ready (out_ready && !sel),
    .out_block (a_out_block),
    .out_last  (a_out_last)
  );

  keccak_pad_absorb #(.R(576), .W(64), .DS(8'h06)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid && sel),
    .in_ready  (b_in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .out_valid (b_out_valid),
    .out_ready (out_ready && sel),
    .out_block (b_out_block),
    .out_last  (b_out_last)
  );

  assign cur_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign cur_out_valid = sel ? b_out_valid : a_out_valid;
  assign cur_out_last  = sel ? b_out_last  : a_out_last;
  assign cur_out_block = sel ? {768'b0, b_out_block} : a_out_block;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1343:0] act, input logic [1343:0] exp);
    int idx;
    total++;
    if (act !== exp) begin
      bad++;
      idx = 0;
      for (int i = 0; i < 168; i++) begin
        if (act[8*i +: 8] !== exp[8*i +: 8]) begin
          idx = i;
          break;
        end
      end
      $display("FAIL %s byte%0d act=%h exp=%h", tag, idx, act[8*idx +: 8], exp[8*idx +: 8]);
    end
  endtask

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    if (rst) begin
      out_ready = 1'b0;
      stall_cnt = 0;
    end else if (cur_out_valid) begin
      check("emit_in_ready", {1343'b0, cur_in_ready}, '0);
      if (sb.size() == 0) begin
        check("unexpected_blk", {1343'b0, cur_out_valid}, '0);
        out_ready = 1'b0;
      end else begin
        check("blk", cur_out_block, sb[0].blk);
        check("last", {1343'b0, cur_out_last}, {1343'b0, sb[0].last});
        if (stall_cnt < stall_n) begin
          stall_cnt++;
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
          stall_cnt = 0;
          void'(sb.pop_front());
        end
      end
    end else begin
      out_ready = 1'b0;
    end
  end

  task automatic make_msg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference pad10*1 model
  task automatic build_exp(input int rb, input bit [7:0] ds);
    int       len;
    int       nblk;
    bit [7:0] pad[];
    exp_t     e;
    len  = msg.size();
    nblk = len / rb + 1;
    pad  = new[nblk * rb];
    for (int i = 0; i < nblk * rb; i++) pad[i] = 8'h00;
    for (int i = 0; i < len; i++) pad[i] = msg[i];
    pad[len]          = pad[len] ^ ds;
    pad[nblk * rb - 1] = pad[nblk * rb - 1] ^ 8'h80;
    for (int b = 0; b < nblk; b++) begin
      e.blk  = '0;
      for (int i = 0; i < rb; i++) e.blk[8*i +: 8] = pad[b*rb + i];
      e.last = (b == nblk - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] nb);
    int cyc;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_bytes = nb;
    cyc = 0;
    while (!cur_in_ready && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 500) check("in_ready_timeout", {1343'b0, cur_in_ready}, 1344'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Drives msg as words; garbage fills bytes beyond the message end.
  // clamp sends an oversize in_bytes on a full last word.
  task automatic drive_msg(input int max_words, input bit clamp);
    int          len;
    int          nw;
    int          nb;
    logic [63:0] d;
    logic        l;
    logic [3:0]  bytes;
    len = msg.size();
    nw  = (len == 0) ? 1 : (len + 7) / 8;
    if (max_words < nw) nw = max_words;
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < 8; b++) begin
        d[8*b +: 8] = (8*w + b < len) ? msg[8*w + b] : 8'($urandom_range(1, 255));
      end
      l  = (w == ((len == 0) ? 0 : (len + 7) / 8 - 1));
      nb = len - 8*w;
      if (l) bytes = (clamp && nb == 8) ? 4'd15 : 4'(nb);
      else   bytes = 4'($urandom_range(0, 15));
      send_word(d, l, bytes);
    end
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("drain", 1344'(sb.size()), '0);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_msg(input bit s, input int len, input int stall, input bit clamp);
    sel     = s;
    stall_n = stall;
    make_msg(len);
    if (s) build_exp(72, 8'h06);
    else   build_exp(168, 8'h1F);
    drive_msg(1000, clamp);
    wait_drain();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    stall_n   = 0;
    stall_cnt = 0;
    sel       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_bytes  = '0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", {1343'b0, cur_out_valid}, '0);
    check("rst_in_ready",  {1343'b0, cur_in_ready}, 1344'd1);
    check("rst_out_last",  {1343'b0, cur_out_last}, '0);
    check("rst_out_block", cur_out_block, '0);
    rst = 1'b0;
    @(negedge clk);

    run_msg(1'b0, 34, 0, 1'b0);   // Kyber seed
    run_msg(1'b0, 0, 0, 1'b0);    // empty message
    run_msg(1'b0, 167, 1, 1'b0);  // domain byte meets pad bit
    run_msg(1'b0, 168, 0, 1'b1);  // exact fill, overflow block
    run_msg(1'b1, 100, 5, 1'b0);  // SHA3-512 with backpressure
    run_msg(1'b1, 144, 2, 1'b0);  // SHA3-512 exact two-block fill
    run_msg(1'b0, 300, 0, 1'b0);  // multi-block SHAKE128

    // Reset after 3 words of a block: nothing may come out afterwards
    sel     = 1'b0;
    stall_n = 0;
    make_msg(34);
    drive_msg(3, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {1343'b0, cur_out_valid}, '0);
    check("mid_rst_in_ready",  {1343'b0, cur_in_ready}, 1344'd1);
    check("mid_rst_out_last",  {1343'b0, cur_out_last}, '0);
    check("mid_rst_out_block", cur_out_block, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_msg(1'b0, 34, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_keccak_pad_absorb
`default_nettype wire
